// File: rtl/console_bus_pkg.sv
// Shared types and bus constants for the console bus arbiter and its picker.
package console_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    localparam int BusAw    = 32;
    localparam int BusDw    = 32;
    localparam int BusBeW   = 4;
    localparam int MaxHosts = 8;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or above ptr, wrapping modulo N.
module bus_rr_pick #(
    parameter int N = 2,
    localparam int IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx,
    output logic            valid
);

    int              pos;
    logic [IdxW-1:0] pos_idx;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        valid   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IdxW'(pos);
            if (!valid && req[pos_idx]) begin
                valid        = 1'b1;
                idx          = pos_idx;
                gnt[pos_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/console_bus_arbiter.sv
// Round-robin arbiter sharing the console device port between several bus hosts,
// with a response timeout that turns a missing device rvalid into an error response.
module console_bus_arbiter
    import console_bus_pkg::*;
#(
    parameter int NumHosts      = 2,
    parameter int TimeoutCycles = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumHosts-1:0]        host_req_i,
    input  logic [NumHosts-1:0]        host_we_i,
    input  logic [BusBeW*NumHosts-1:0] host_be_i,
    input  logic [BusAw*NumHosts-1:0]  host_addr_i,
    input  logic [BusDw*NumHosts-1:0]  host_wdata_i,
    output logic [NumHosts-1:0]        host_gnt_o,
    output logic [NumHosts-1:0]        host_rvalid_o,
    output logic [NumHosts-1:0]        host_err_o,
    output logic [BusDw*NumHosts-1:0]  host_rdata_o,
    output logic                       dev_req_o,
    output logic                       dev_we_o,
    output logic [BusBeW-1:0]          dev_be_o,
    output logic [BusAw-1:0]           dev_addr_o,
    output logic [BusDw-1:0]           dev_wdata_o,
    input  logic                       dev_rvalid_i,
    input  logic [BusDw-1:0]           dev_rdata_i
);

    localparam int         IdxW    = $clog2(NumHosts);
    localparam logic [3:0] CntLast = 4'(TimeoutCycles - 1);

    arb_state_e          state, state_d;
    logic [IdxW-1:0]     owner, rr_ptr, pick_idx;
    logic [3:0]          cnt;
    logic [NumHosts-1:0] pick_gnt;
    logic                pick_valid, resp_ok, timeout, arb_en, grant;

    logic [BusBeW-1:0] be_a    [NumHosts];
    logic [BusAw-1:0]  addr_a  [NumHosts];
    logic [BusDw-1:0]  wdata_a [NumHosts];
    logic [BusDw-1:0]  rdata_a [NumHosts];

    for (genvar k = 0; k < NumHosts; k++) begin : g_lane
        assign be_a[k]                          = host_be_i[k*BusBeW +: BusBeW];
        assign addr_a[k]                        = host_addr_i[k*BusAw +: BusAw];
        assign wdata_a[k]                       = host_wdata_i[k*BusDw +: BusDw];
        assign host_rdata_o[k*BusDw +: BusDw]   = rdata_a[k];
    end

    bus_rr_pick #(.N(NumHosts)) u_pick (
        .req   (host_req_i),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // A response or timeout frees the port in the same cycle, so a new grant can overlap it.
    assign resp_ok = (state == WAIT) && dev_rvalid_i;
    assign timeout = (state == WAIT) && !dev_rvalid_i && (cnt == CntLast);
    assign arb_en  = (state == IDLE) || resp_ok || timeout;
    assign grant   = arb_en && pick_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (grant) begin
            state_d = WAIT;
        end else if (resp_ok || timeout) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else if (grant) begin
            owner  <= pick_idx;
            rr_ptr <= (pick_idx == IdxW'(NumHosts - 1)) ? '0 : pick_idx + 1'b1;
            cnt    <= '0;
        end else if (state == WAIT) begin
            cnt    <= cnt + 4'd1;
        end
    end

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        dev_req_o     = 1'b0;
        dev_we_o      = 1'b0;
        dev_be_o      = '0;
        dev_addr_o    = '0;
        dev_wdata_o   = '0;
        for (int k = 0; k < NumHosts; k++) begin
            rdata_a[k] = '0;
        end
        if (grant) begin
            host_gnt_o  = pick_gnt;
            dev_req_o   = 1'b1;
            dev_we_o    = host_we_i[pick_idx];
            dev_be_o    = be_a[pick_idx];
            dev_addr_o  = addr_a[pick_idx];
            dev_wdata_o = wdata_a[pick_idx];
        end
        if (resp_ok) begin
            host_rvalid_o[owner] = 1'b1;
            rdata_a[owner]       = dev_rdata_i;
        end else if (timeout) begin
            host_rvalid_o[owner] = 1'b1;
            host_err_o[owner]    = 1'b1;
        end
    end

endmodule
